// File: rtl/frame_sync_ctrl.sv
//==============================================================================
// frame_sync_ctrl : FAS hunt/presync/sync frame-alignment controller ahead of the demapper.
// Optional statistics counters built when FSYNC_STATS_EN is defined.
// Revision: 1.0
//==============================================================================
`default_nettype none

module frame_sync_ctrl #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 1024,
    parameter int SYNC_CONFIRM   = 2,
    parameter int LOSS_THRESH    = 3,
    parameter int CRC_ERR_THRESH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_frame_data,
    input  logic        i_frame_data_valid,
    input  logic        i_frame_data_fas,
    input  logic        i_crc_err,
    output logic [7:0]  o_frame_data,
    output logic        o_frame_data_valid,
    output logic        o_frame_data_fas,
    output logic        o_fpc_restart,
    output logic        o_in_frame,
    output logic        o_lof,
    output logic [1:0]  o_state,
    output logic [15:0] o_lof_cnt,
    output logic [15:0] o_crc_err_cnt
);

    localparam int FRAME_LEN = NUM_ROWS * NUM_COLS;
    localparam int PW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int MW        = $clog2(SYNC_CONFIRM + 1);
    localparam int LW        = $clog2(LOSS_THRESH + 1);
    localparam int CW        = $clog2(CRC_ERR_THRESH + 1);

    localparam logic [PW-1:0] C_POS_LAST     = PW'(FRAME_LEN - 1);
    localparam logic [MW-1:0] C_SYNC_CONFIRM = MW'(SYNC_CONFIRM);
    localparam logic [LW-1:0] C_LOSS_THRESH  = LW'(LOSS_THRESH);
    localparam logic [CW-1:0] C_CRC_THRESH   = CW'(CRC_ERR_THRESH);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'b00,
        ST_PRESYNC = 2'b01,
        ST_SYNC    = 2'b10
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_pos, w_pos_nxt, w_pos_inc;
    logic [MW-1:0] r_match, w_match_nxt, w_match_inc;
    logic [LW-1:0] r_miss, w_miss_nxt;
    logic [CW-1:0] r_crcerr, w_crcerr_nxt;
    logic          r_crc_seen, w_crc_seen_nxt;
    logic [7:0]    r_out_data;
    logic          r_out_valid, r_out_fas, r_lof;
    logic          w_slot, w_valid_fas, w_fwd, w_exit;

    assign w_slot      = i_frame_data_valid && (r_pos == '0);
    assign w_valid_fas = i_frame_data_valid && i_frame_data_fas;
    assign w_pos_inc   = (r_pos == C_POS_LAST) ? '0 : r_pos + PW'(1);
    assign w_match_inc = r_match + MW'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_pos_nxt      = r_pos;
        w_match_nxt    = r_match;
        w_miss_nxt     = r_miss;
        w_crcerr_nxt   = r_crcerr;
        w_crc_seen_nxt = r_crc_seen;
        w_fwd          = 1'b0;
        w_exit         = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_valid_fas) begin
                    w_pos_nxt = PW'(1);
                    if (SYNC_CONFIRM == 1) begin
                        w_state_nxt = ST_SYNC;
                        w_fwd       = 1'b1;
                    end else begin
                        w_state_nxt = ST_PRESYNC;
                        w_match_nxt = MW'(1);
                    end
                end
            end
            ST_PRESYNC: begin
                if (w_slot) begin
                    if (i_frame_data_fas) begin
                        w_pos_nxt   = PW'(1);
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == C_SYNC_CONFIRM) begin
                            // Forward the confirming FAS so the demapper starts on a frame head.
                            w_state_nxt = ST_SYNC;
                            w_match_nxt = '0;
                            w_fwd       = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_HUNT;
                        w_match_nxt = '0;
                    end
                end else if (w_valid_fas) begin
                    w_pos_nxt   = PW'(1);
                    w_match_nxt = MW'(1);
                end else if (i_frame_data_valid) begin
                    w_pos_nxt = w_pos_inc;
                end
            end
            ST_SYNC: begin
                if (i_crc_err) begin
                    w_crcerr_nxt = r_crcerr + CW'(1);
                    if (w_crcerr_nxt == C_CRC_THRESH) w_exit = 1'b1;
                end
                if (w_slot) begin
                    if (i_frame_data_fas) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_miss_nxt = r_miss + LW'(1);
                        if (w_miss_nxt == C_LOSS_THRESH) w_exit = 1'b1;
                    end
                    // A frame with no CRC failure breaks the consecutive-error run.
                    if (!r_crc_seen && !i_crc_err) w_crcerr_nxt = '0;
                    w_crc_seen_nxt = 1'b0;
                end else begin
                    w_crc_seen_nxt = r_crc_seen | i_crc_err;
                end
                if (i_frame_data_valid) w_pos_nxt = w_pos_inc;
                if (w_exit) begin
                    w_state_nxt    = ST_HUNT;
                    w_miss_nxt     = '0;
                    w_crcerr_nxt   = '0;
                    w_match_nxt    = '0;
                    w_crc_seen_nxt = 1'b0;
                end else begin
                    w_fwd = i_frame_data_valid;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_HUNT;
            r_pos       <= '0;
            r_match     <= '0;
            r_miss      <= '0;
            r_crcerr    <= '0;
            r_crc_seen  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_fas   <= 1'b0;
            r_lof       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_match     <= w_match_nxt;
            r_miss      <= w_miss_nxt;
            r_crcerr    <= w_crcerr_nxt;
            r_crc_seen  <= w_crc_seen_nxt;
            r_out_valid <= w_fwd;
            r_out_fas   <= w_fwd & i_frame_data_fas;
            r_lof       <= w_exit;
            if (w_fwd) r_out_data <= i_frame_data;
        end
    end

    assign o_frame_data       = r_out_data;
    assign o_frame_data_valid = r_out_valid;
    assign o_frame_data_fas   = r_out_fas;
    assign o_fpc_restart      = r_lof;
    assign o_lof              = r_lof;
    assign o_in_frame         = (r_state == ST_SYNC);
    assign o_state            = r_state;

`ifdef FSYNC_STATS_EN
    logic [15:0] r_lof_cnt, r_crc_err_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lof_cnt     <= '0;
            r_crc_err_cnt <= '0;
        end else begin
            if (w_exit && (r_lof_cnt != 16'hFFFF)) r_lof_cnt <= r_lof_cnt + 16'd1;
            if ((r_state == ST_SYNC) && i_crc_err && (r_crc_err_cnt != 16'hFFFF))
                r_crc_err_cnt <= r_crc_err_cnt + 16'd1;
        end
    end

    assign o_lof_cnt     = r_lof_cnt;
    assign o_crc_err_cnt = r_crc_err_cnt;
`else
    assign o_lof_cnt     = 16'h0;
    assign o_crc_err_cnt = 16'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_sync_ctrl.sv
//==============================================================================
// tb_frame_sync_ctrl : randomized self-checking bench for frame_sync_ctrl (FRAME_LEN=32).
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_frame_sync_ctrl;

    localparam int NUM_ROWS       = 4;
    localparam int NUM_COLS       = 8;
    localparam int FRAME_LEN      = NUM_ROWS * NUM_COLS;
    localparam int SYNC_CONFIRM   = 2;
    localparam int LOSS_THRESH    = 3;
    localparam int CRC_ERR_THRESH = 4;
    localparam int HUNT = 0, PRESYNC = 1, SYNC = 2;
`ifdef FSYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  frame_data;
    logic        frame_data_valid, frame_data_fas, crc_err;
    logic [7:0]  out_data;
    logic        out_valid, out_fas, fpc_restart, in_frame, lof;
    logic [1:0]  state;
    logic [15:0] lof_cnt, crc_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame-level alignment rules tracked with plain integers.
    int         m_state, m_pos, m_match, m_miss, m_crc;
    bit         m_crc_seen;
    bit         e_valid, e_fas, e_lof;
    logic [7:0] e_data;
    int         e_lof_cnt, e_crc_cnt;

    always #5 clk = ~clk;

    frame_sync_ctrl #(
        .NUM_ROWS       (NUM_ROWS),
        .NUM_COLS       (NUM_COLS),
        .SYNC_CONFIRM   (SYNC_CONFIRM),
        .LOSS_THRESH    (LOSS_THRESH),
        .CRC_ERR_THRESH (CRC_ERR_THRESH)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_frame_data       (frame_data),
        .i_frame_data_valid (frame_data_valid),
        .i_frame_data_fas   (frame_data_fas),
        .i_crc_err          (crc_err),
        .o_frame_data       (out_data),
        .o_frame_data_valid (out_valid),
        .o_frame_data_fas   (out_fas),
        .o_fpc_restart      (fpc_restart),
        .o_in_frame         (in_frame),
        .o_lof              (lof),
        .o_state            (state),
        .o_lof_cnt          (lof_cnt),
        .o_crc_err_cnt      (crc_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = HUNT; m_pos = 0; m_match = 0; m_miss = 0; m_crc = 0; m_crc_seen = 0;
        e_valid = 0; e_fas = 0; e_lof = 0; e_data = 8'h00;
        e_lof_cnt = 0; e_crc_cnt = 0;
    endtask

    task automatic model_step(input bit v, input bit f, input logic [7:0] d, input bit c);
        bit fwd, leave, slot;
        fwd   = 0;
        leave = 0;
        slot  = v && (m_pos == 0);
        if (m_state == HUNT) begin
            if (v && f) begin
                m_pos = 1;
                if (SYNC_CONFIRM == 1) begin m_state = SYNC; fwd = 1; end
                else begin m_state = PRESYNC; m_match = 1; end
            end
        end else if (m_state == PRESYNC) begin
            if (slot && f) begin
                m_pos = 1;
                m_match++;
                if (m_match >= SYNC_CONFIRM) begin m_state = SYNC; m_match = 0; fwd = 1; end
            end else if (slot) begin
                m_state = HUNT; m_match = 0;
            end else if (v && f) begin
                m_pos = 1; m_match = 1;
            end else if (v) begin
                m_pos = (m_pos + 1) % FRAME_LEN;
            end
        end else begin
            if (c) begin
                m_crc++;
                if (m_crc == CRC_ERR_THRESH) leave = 1;
                if (STATS && e_crc_cnt < 65535) e_crc_cnt++;
            end
            if (slot) begin
                if (f) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == LOSS_THRESH) leave = 1;
                end
                if (!m_crc_seen && !c) m_crc = 0;
                m_crc_seen = 0;
            end else if (c) begin
                m_crc_seen = 1;
            end
            if (v) m_pos = (m_pos + 1) % FRAME_LEN;
            if (leave) begin
                m_state = HUNT; m_miss = 0; m_crc = 0; m_match = 0; m_crc_seen = 0;
                if (STATS && e_lof_cnt < 65535) e_lof_cnt++;
            end else begin
                fwd = v;
            end
        end
        e_valid = fwd;
        e_fas   = fwd && f;
        e_lof   = leave;
        if (fwd) e_data = d;
    endtask

    task automatic check_all();
        check("state",     32'(state),        32'(m_state));
        check("in_frame",  32'(in_frame),     32'(m_state == SYNC));
        check("out_valid", 32'(out_valid),    32'(e_valid));
        check("out_fas",   32'(out_fas),      32'(e_fas));
        check("out_data",  32'(out_data),     32'(e_data));
        check("lof",       32'(lof),          32'(e_lof));
        check("restart",   32'(fpc_restart),  32'(e_lof));
        check("lof_cnt",   32'(lof_cnt),      32'(e_lof_cnt));
        check("crc_cnt",   32'(crc_err_cnt),  32'(e_crc_cnt));
    endtask

    task automatic drive_cycle(input bit v, input bit f, input logic [7:0] d, input bit c);
        frame_data_valid = v;
        frame_data_fas   = f;
        frame_data       = d;
        crc_err          = c;
        @(posedge clk);
        model_step(v, f, d, c);
        #1;
        check_all();
    endtask

    // One valid byte, sometimes preceded by an idle cycle carrying fas noise.
    task automatic send_byte(input bit f, input bit c);
        if ($urandom_range(0, 3) == 0)
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        drive_cycle(1'b1, f, 8'($urandom), c);
    endtask

    task automatic send_body(input int n, input int crc_at);
        for (int i = 0; i < n; i++) send_byte(1'b0, i == crc_at);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        frame_data = 8'h00; frame_data_valid = 1'b0; frame_data_fas = 1'b0; crc_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_state", 32'(state), 32'(HUNT));
        rst = 1'b0;

        // Clean acquisition: PRESYNC on FAS#1, SYNC on FAS#2 which is forwarded.
        send_byte(1'b1, 1'b0);
        check("t1_presync", 32'(state), 32'(PRESYNC));
        send_body(FRAME_LEN - 1, -1);
        send_byte(1'b1, 1'b0);
        check("t1_sync",    32'(state),    32'(SYNC));
        check("t1_fwd_fas", 32'(out_fas),  32'd1);
        check("t1_inframe", 32'(in_frame), 32'd1);

        // Three missed FAS slots force loss of frame.
        send_body(FRAME_LEN - 1, -1);
        for (int k = 0; k < 3; k++) begin
            send_byte(1'b0, 1'b0);
            if (k < 2) send_body(FRAME_LEN - 1, -1);
        end
        check("t2_lof",     32'(lof),         32'd1);
        check("t2_restart", 32'(fpc_restart), 32'd1);
        check("t2_hunt",    32'(state),       32'(HUNT));
        check("t2_nofwd",   32'(out_valid),   32'd0);
        send_byte(1'b0, 1'b0);
        check("t2_lof_once", 32'(lof), 32'd0);

        // Re-acquire, then two misses followed by a good FAS keep SYNC.
        send_byte(1'b1, 1'b0);
        send_body(FRAME_LEN - 1, -1);
        send_byte(1'b1, 1'b0);
        send_body(FRAME_LEN - 1, -1);
        for (int k = 0; k < 2; k++) begin
            send_byte(1'b0, 1'b0);
            send_body(FRAME_LEN - 1, -1);
        end
        send_byte(1'b1, 1'b0);
        check("t2_keep_sync", 32'(state), 32'(SYNC));

        // Four consecutive CRC-failed frames: loss on the fourth pulse.
        for (int k = 0; k < 3; k++) begin
            send_body(FRAME_LEN - 1, 10);
            send_byte(1'b1, 1'b0);
        end
        send_body(10, -1);
        send_byte(1'b0, 1'b1);
        check("t4_lof",  32'(lof),   32'd1);
        check("t4_hunt", 32'(state), 32'(HUNT));
        check("t6_lof_cnt", 32'(lof_cnt),     STATS ? 32'd2 : 32'd0);
        check("t6_crc_cnt", 32'(crc_err_cnt), STATS ? 32'd4 : 32'd0);

        // Error, clean, error frames do not lose alignment.
        send_byte(1'b1, 1'b0);
        send_body(FRAME_LEN - 1, -1);
        send_byte(1'b1, 1'b0);
        send_body(FRAME_LEN - 1, 10);
        send_byte(1'b1, 1'b0);
        send_body(FRAME_LEN - 1, -1);
        send_byte(1'b1, 1'b0);
        send_body(FRAME_LEN - 1, 10);
        send_byte(1'b1, 1'b0);
        check("t4_keep_sync", 32'(state), 32'(SYNC));

        // Asynchronous reset mid-frame clears outputs before any clock edge.
        send_body(5, -1);
        frame_data_valid = 1'b0; frame_data_fas = 1'b0; crc_err = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("t5_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // PRESYNC re-arm on a misplaced FAS; SYNC one frame after the re-arm.
        send_byte(1'b1, 1'b0);
        send_body(19, -1);
        send_byte(1'b1, 1'b0);
        check("t3_rearm", 32'(state), 32'(PRESYNC));
        send_body(FRAME_LEN - 1, -1);
        check("t3_wait", 32'(state), 32'(PRESYNC));
        send_byte(1'b1, 1'b0);
        check("t3_sync", 32'(state), 32'(SYNC));

        // Randomized frames: dropped FAS, stray FAS and CRC pulses.
        for (int fr = 0; fr < 60; fr++) begin
            bit drop;
            int crc_at, bad_at;
            drop   = ($urandom_range(0, 3) == 0);
            crc_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, FRAME_LEN - 1)) : -1;
            bad_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, FRAME_LEN - 1)) : -1;
            send_byte(!drop, 1'b0);
            for (int b = 1; b < FRAME_LEN; b++) send_byte(b == bad_at, b == crc_at);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
